// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU instruction sequencer: state encoding and default widths.
package cpu_seq_pkg;

  localparam int unsigned DefAddrWidth   = 5;
  localparam int unsigned DefOpcodeWidth = 4;

  typedef enum logic [1:0] {
    StHalt   = 2'd0,
    StFetch  = 2'd1,
    StExec   = 2'd2,
    StSquash = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: run/step control, ROM address/data, decoder and datapath enables.
// CPU_SEQ_BREAKPOINT_EN adds the bp_addr/bp_hit breakpoint signals.
interface cpu_sequencer_if
  import cpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned OPCODE_WIDTH = DefOpcodeWidth
);

  logic                    run;
  logic                    step;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    skip_taken;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [OPCODE_WIDTH-1:0] ir;
  logic                    exec_en;
  logic                    halted;
  logic                    wrapped;
`ifdef CPU_SEQ_BREAKPOINT_EN
  logic [ADDR_WIDTH-1:0]   bp_addr;
  logic                    bp_hit;

  modport master (
    output run, step, opcode, skip_taken, bp_addr,
    input  pc, ir, exec_en, halted, wrapped, bp_hit
  );

  modport slave (
    input  run, step, opcode, skip_taken, bp_addr,
    output pc, ir, exec_en, halted, wrapped, bp_hit
  );
`else
  modport master (
    output run, step, opcode, skip_taken,
    input  pc, ir, exec_en, halted, wrapped
  );

  modport slave (
    input  run, step, opcode, skip_taken,
    output pc, ir, exec_en, halted, wrapped
  );
`endif

endinterface

// File: rtl/cpu_sequencer_counter.sv
// Program counter: synchronous-reset up-counter, wraps modulo 2^WIDTH.
module Counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (enable) begin
      out <= out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: owns PC and IR, run/halt/single-step control and skip squashing.
// CPU_SEQ_BREAKPOINT_EN enables the PC breakpoint compare in FETCH.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned OPCODE_WIDTH = DefOpcodeWidth
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.slave  bus
);

  seq_state_e              state_q, state_d;
  logic                    step_mode_q, step_mode_d;
  logic [OPCODE_WIDTH-1:0] ir_q;
  logic                    wrapped_q;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    pc_en;
  logic                    fetch_ok;
  logic                    bp_divert;

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic first_fetch_q;
  logic bp_hit_q;
  logic leaving_halt;

  // The first fetch after a resume skips the compare so execution moves past the breakpoint.
  assign bp_divert    = (state_q == StFetch) && !first_fetch_q && (pc == bus.bp_addr);
  assign leaving_halt = (state_q == StHalt) && (state_d != StHalt);

  always_ff @(posedge clk) begin
    if (reset) begin
      first_fetch_q <= 1'b0;
      bp_hit_q      <= 1'b0;
    end else begin
      if (leaving_halt) begin
        first_fetch_q <= 1'b1;
        bp_hit_q      <= 1'b0;
      end else if (state_q == StFetch) begin
        first_fetch_q <= 1'b0;
      end
      if (bp_divert) begin
        bp_hit_q <= 1'b1;
      end
    end
  end

  assign bus.bp_hit = bp_hit_q;
`else
  assign bp_divert = 1'b0;
`endif

  assign fetch_ok = (state_q == StFetch) && !bp_divert;
  assign pc_en    = fetch_ok || (state_q == StSquash);

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    unique case (state_q)
      StHalt: begin
        if (bus.run) begin
          state_d     = StFetch;
          step_mode_d = 1'b0;
        end else if (bus.step) begin
          state_d     = StFetch;
          step_mode_d = 1'b1;
        end
      end
      StFetch: begin
        state_d = bp_divert ? StHalt : StExec;
      end
      StExec: begin
        if (bus.skip_taken) begin
          state_d = StSquash;
        end else if (step_mode_q || !bus.run) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StSquash: begin
        state_d = (step_mode_q || !bus.run) ? StHalt : StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHalt;
      step_mode_q <= 1'b0;
      ir_q        <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      if (fetch_ok) begin
        ir_q <= bus.opcode;
      end
      // High in the first cycle the counter shows 0 after rolling over.
      wrapped_q <= pc_en && (pc == '1);
    end
  end

  Counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_pc_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (pc_en),
    .out    (pc)
  );

  assign bus.pc      = pc;
  assign bus.ir      = ir_q;
  assign bus.exec_en = (state_q == StExec);
  assign bus.halted  = (state_q == StHalt);
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer against a fixed ROM image.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int unsigned AW = DefAddrWidth;
  localparam int unsigned OW = DefOpcodeWidth;

  logic clk = 1'b0;
  logic reset;
  logic skip_arm;
  logic found;
  logic [OW-1:0] rom [1 << AW];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) bus ();

  cpu_sequencer #(
    .ADDR_WIDTH   (AW),
    .OPCODE_WIDTH (OW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.opcode     = rom[bus.pc];
  // Skip taken on the EXEC of address 3 (pc has already advanced to 4).
  assign bus.skip_taken = skip_arm && bus.exec_en && (bus.pc == AW'(4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = OW'((i * 7 + 3) % 16);
    reset    = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    skip_arm = 1'b0;
    found    = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
    bus.bp_addr = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_halted", 32'(bus.halted), 32'd1);
    check_eq("rst_pc", 32'(bus.pc), 32'd0);
    check_eq("rst_ir", 32'(bus.ir), 32'd0);
    check_eq("rst_exec_en", 32'(bus.exec_en), 32'd0);
    check_eq("rst_wrapped", 32'(bus.wrapped), 32'd0);
`ifdef CPU_SEQ_BREAKPOINT_EN
    check_eq("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_halted", 32'(bus.halted), 32'd1);
      check_eq("idle_pc", 32'(bus.pc), 32'd0);
      check_eq("idle_exec_en", 32'(bus.exec_en), 32'd0);
    end

`ifdef CPU_SEQ_BREAKPOINT_EN
    bus.bp_addr = AW'(6);
    bus.run     = 1'b1;
    tick();
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (bus.halted) found = 1'b1;
    end
    bus.run = 1'b0;
    check_eq("bp_reached", 32'(found), 32'd1);
    check_eq("bp_pc", 32'(bus.pc), 32'd6);
    check_eq("bp_hit_set", 32'(bus.bp_hit), 32'd1);
    check_eq("bp_ir", 32'(bus.ir), 32'(rom[5]));
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check_eq("bp_hit_clr", 32'(bus.bp_hit), 32'd0);
    check_eq("bp_resume", 32'(bus.halted), 32'd0);
    tick();
    check_eq("bp_step_exec", 32'(bus.exec_en), 32'd1);
    check_eq("bp_step_ir", 32'(bus.ir), 32'(rom[6]));
    check_eq("bp_step_pc", 32'(bus.pc), 32'd7);
    tick();
    check_eq("bp_step_halt", 32'(bus.halted), 32'd1);
    check_eq("bp_step_pc_hold", 32'(bus.pc), 32'd7);
`else
    // Free run: two cycles per instruction, first exec_en two cycles after run.
    bus.run = 1'b1;
    tick();
    check_eq("lat_fetch_exec_en", 32'(bus.exec_en), 32'd0);
    tick();
    for (int n = 0; n < 3; n++) begin
      check_eq("run_exec_en", 32'(bus.exec_en), 32'd1);
      check_eq("run_ir", 32'(bus.ir), 32'(rom[n]));
      check_eq("run_pc", 32'(bus.pc), 32'(n + 1));
      tick();
      check_eq("run_fetch_exec_en", 32'(bus.exec_en), 32'd0);
      check_eq("run_fetch_pc", 32'(bus.pc), 32'(n + 1));
      tick();
    end
    skip_arm = 1'b1;
    check_eq("skip_exec_ir", 32'(bus.ir), 32'(rom[3]));
    check_eq("skip_exec_pc", 32'(bus.pc), 32'd4);
    tick();
    skip_arm = 1'b0;
    check_eq("squash_exec_en", 32'(bus.exec_en), 32'd0);
    check_eq("squash_pc", 32'(bus.pc), 32'd4);
    check_eq("squash_ir", 32'(bus.ir), 32'(rom[3]));
    tick();
    check_eq("post_squash_fetch_pc", 32'(bus.pc), 32'd5);
    check_eq("post_squash_exec_en", 32'(bus.exec_en), 32'd0);
    tick();
    check_eq("post_skip_exec_en", 32'(bus.exec_en), 32'd1);
    check_eq("post_skip_ir", 32'(bus.ir), 32'(rom[5]));
    check_eq("post_skip_pc", 32'(bus.pc), 32'd6);
    tick();
    tick();
    check_eq("exec6_ir", 32'(bus.ir), 32'(rom[6]));
    bus.run = 1'b0;
    tick();
    check_eq("stop_halted", 32'(bus.halted), 32'd1);
    check_eq("stop_pc", 32'(bus.pc), 32'd7);

    // Single step; a second step during EXEC must be dropped.
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check_eq("step_fetch_halted", 32'(bus.halted), 32'd0);
    check_eq("step_fetch_exec_en", 32'(bus.exec_en), 32'd0);
    tick();
    check_eq("step_exec_en", 32'(bus.exec_en), 32'd1);
    check_eq("step_ir", 32'(bus.ir), 32'(rom[7]));
    check_eq("step_pc", 32'(bus.pc), 32'd8);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check_eq("step_done_halted", 32'(bus.halted), 32'd1);
    check_eq("step_done_pc", 32'(bus.pc), 32'd8);
    tick();
    check_eq("step_ignored_halted", 32'(bus.halted), 32'd1);
    check_eq("step_ignored_exec_en", 32'(bus.exec_en), 32'd0);
    check_eq("step_ignored_pc", 32'(bus.pc), 32'd8);

    // Run up to the wrap, then reset during an EXEC.
    bus.run = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (bus.exec_en && bus.pc == AW'(30)) found = 1'b1;
    end
    check_eq("reach_pc30", 32'(found), 32'd1);
    tick();
    check_eq("fetch30_pc", 32'(bus.pc), 32'd30);
    tick();
    check_eq("exec30_pc", 32'(bus.pc), 32'd31);
    check_eq("exec30_ir", 32'(bus.ir), 32'(rom[30]));
    tick();
    check_eq("fetch31_wrapped", 32'(bus.wrapped), 32'd0);
    tick();
    check_eq("wrap_pc", 32'(bus.pc), 32'd0);
    check_eq("wrap_flag", 32'(bus.wrapped), 32'd1);
    check_eq("wrap_ir", 32'(bus.ir), 32'(rom[31]));
    tick();
    check_eq("wrap_flag_clr", 32'(bus.wrapped), 32'd0);
    check_eq("wrap_fetch_pc", 32'(bus.pc), 32'd0);
    tick();
    check_eq("pre_rst_exec_en", 32'(bus.exec_en), 32'd1);
    check_eq("pre_rst_ir", 32'(bus.ir), 32'(rom[0]));
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.run = 1'b0;
    check_eq("midrst_exec_en", 32'(bus.exec_en), 32'd0);
    check_eq("midrst_pc", 32'(bus.pc), 32'd0);
    check_eq("midrst_halted", 32'(bus.halted), 32'd1);
    check_eq("midrst_ir", 32'(bus.ir), 32'd0);
    tick();
    check_eq("post_rst_halted", 32'(bus.halted), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
